// File: rtl/simon_sequencer.sv
// Simon Says engine: replays a growing colour sequence, then checks player presses against it.
// All outputs registered (start -> show_valid next cycle); presses outside INPUT and starts mid-game are dropped.
module simon_sequencer #(
    parameter int NUM_COLORS     = 4,
    parameter int COLOR_W        = 2,
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int SCORE_W        = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       strict,
    input  logic [MAX_LEN*COLOR_W-1:0] seq,
    input  logic                       btn_valid,
    input  logic [COLOR_W-1:0]         btn_color,
    output logic                       show_valid,
    output logic [COLOR_W-1:0]         show_color,
    output logic                       awaiting_input,
    output logic [SCORE_W-1:0]         score,
    output logic [SCORE_W-1:0]         level,
    output logic                       game_over,
    output logic                       win
);

    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int T_MAX   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_INPUT,
        S_LOSE,
        S_WIN
    } state_t;

    state_t                     state_q, state_d;
    logic [MAX_LEN*COLOR_W-1:0] seq_q, seq_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [TIMER_W-1:0]         timer_q, timer_d;
    logic [TO_W-1:0]            tcnt_q, tcnt_d;
    logic [SCORE_W-1:0]         score_q, score_d;
    logic [SCORE_W-1:0]         level_q, level_d;
    logic                       show_valid_q, show_valid_d;
    logic [COLOR_W-1:0]         show_color_q, show_color_d;
    logic                       awaiting_q, awaiting_d;
    logic                       game_over_q, game_over_d;
    logic                       win_q, win_d;

    logic last_elem;
    logic color_ok;
    logic miss;

    assign last_elem = (SCORE_W'(idx_q) == level_q - SCORE_W'(1));
    // A code beyond the colour range never matches, even if the stored sequence holds it.
    assign color_ok  = ({1'b0, btn_color} < (COLOR_W+1)'(NUM_COLORS)) &&
                       (btn_color == seq_q[idx_q*COLOR_W +: COLOR_W]);

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        tcnt_d  = tcnt_q;
        score_d = score_q;
        level_d = level_q;
        miss    = 1'b0;

        case (state_q)
            S_IDLE, S_LOSE, S_WIN: begin
                if (start) begin
                    seq_d   = seq;
                    level_d = SCORE_W'(1);
                    score_d = '0;
                    idx_d   = '0;
                    timer_d = TIMER_W'(SHOW_CYCLES - 1);
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_W'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (last_elem) begin
                    idx_d   = '0;
                    tcnt_d  = '0;
                    state_d = S_INPUT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    timer_d = TIMER_W'(SHOW_CYCLES - 1);
                    state_d = S_SHOW;
                end
            end
            S_INPUT: begin
                if (btn_valid) begin
                    if (!color_ok) begin
                        miss = 1'b1;
                    end else if (!last_elem) begin
                        idx_d  = idx_q + IDX_W'(1);
                        tcnt_d = '0;
                    end else begin
                        score_d = score_q + SCORE_W'(1);
                        if (level_q == SCORE_W'(MAX_LEN)) begin
                            state_d = S_WIN;
                        end else begin
                            level_d = level_q + SCORE_W'(1);
                            idx_d   = '0;
                            timer_d = TIMER_W'(SHOW_CYCLES - 1);
                            state_d = S_SHOW;
                        end
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        miss = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                if (miss) begin
                    if (strict) begin
                        state_d = S_LOSE;
                    end else begin
                        idx_d   = '0;
                        timer_d = TIMER_W'(SHOW_CYCLES - 1);
                        state_d = S_SHOW;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land in flops alongside it.
        show_valid_d = (state_d == S_SHOW);
        show_color_d = (state_d == S_SHOW) ? seq_d[idx_d*COLOR_W +: COLOR_W] : '0;
        awaiting_d   = (state_d == S_INPUT);
        game_over_d  = (state_d == S_LOSE);
        win_d        = (state_d == S_WIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            seq_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            tcnt_q       <= '0;
            score_q      <= '0;
            level_q      <= '0;
            show_valid_q <= 1'b0;
            show_color_q <= '0;
            awaiting_q   <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            tcnt_q       <= tcnt_d;
            score_q      <= score_d;
            level_q      <= level_d;
            show_valid_q <= show_valid_d;
            show_color_q <= show_color_d;
            awaiting_q   <= awaiting_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
        end
    end

    assign show_valid     = show_valid_q;
    assign show_color     = show_color_q;
    assign awaiting_input = awaiting_q;
    assign score          = score_q;
    assign level          = level_q;
    assign game_over      = game_over_q;
    assign win            = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench: 4-colour/4-long game with no timeout, plus a 3-colour instance with an 8-cycle timeout.
module tb_simon_sequencer;

    typedef logic [11:0] obs_t; // {show_valid, show_color, awaiting, score, level, game_over, win}

    typedef struct {
        logic start;
        logic bv;
        logic [1:0] bc;
        obs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       strict = 1'b1;
    logic [7:0] seq = 8'h36;
    logic [7:0] seq2 = 8'h07;

    logic       start = 1'b0, btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0;
    logic       show_valid, awaiting_input, game_over, win;
    logic [1:0] show_color;
    logic [2:0] score, level;

    logic       start2 = 1'b0, btn_valid2 = 1'b0;
    logic [1:0] btn_color2 = 2'd0;
    logic       show_valid2, awaiting_input2, game_over2, win2;
    logic [1:0] show_color2;
    logic [2:0] score2, level2;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    simon_sequencer #(.NUM_COLORS(4), .COLOR_W(2), .MAX_LEN(4), .SHOW_CYCLES(2),
                      .GAP_CYCLES(1), .TIMEOUT_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .start(start), .strict(strict), .seq(seq),
        .btn_valid(btn_valid), .btn_color(btn_color),
        .show_valid(show_valid), .show_color(show_color), .awaiting_input(awaiting_input),
        .score(score), .level(level), .game_over(game_over), .win(win)
    );

    simon_sequencer #(.NUM_COLORS(3), .COLOR_W(2), .MAX_LEN(4), .SHOW_CYCLES(2),
                      .GAP_CYCLES(1), .TIMEOUT_CYCLES(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .strict(strict), .seq(seq2),
        .btn_valid(btn_valid2), .btn_color(btn_color2),
        .show_valid(show_valid2), .show_color(show_color2), .awaiting_input(awaiting_input2),
        .score(score2), .level(level2), .game_over(game_over2), .win(win2)
    );

    function automatic obs_t mk(input logic sv, input int c, input logic aw,
                                input int sc, input int lv, input logic go, input logic w);
        return {sv, 2'(c), aw, 3'(sc), 3'(lv), go, w};
    endfunction

    function automatic obs_t obs1();
        return {show_valid, show_color, awaiting_input, score, level, game_over, win};
    endfunction

    function automatic obs_t obs2();
        return {show_valid2, show_color2, awaiting_input2, score2, level2, game_over2, win2};
    endfunction

    task automatic add(input logic s, input logic bv, input int bc, input obs_t e);
        vec_t v;
        v.start = s;
        v.bv    = bv;
        v.bc    = 2'(bc);
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got sv/col/aw/score/lvl/go/win=%b_%0d_%b_%0d_%0d_%b_%b expected %b_%0d_%b_%0d_%0d_%b_%b",
                     name, act[11], act[10:9], act[8], act[7:5], act[4:2], act[1], act[0],
                     exp[11], exp[10:9], exp[8], exp[7:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // One clock: inputs set by the caller are sampled, outputs settle, pulses drop.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;  btn_valid = 1'b0;
        start2 = 1'b0; btn_valid2 = 1'b0;
    endtask

    task automatic press(input int c);
        btn_valid = 1'b1;
        btn_color = 2'(c);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Full perfect game on seq 2,1,3,0 with stray start/presses during display.
        add(1, 0, 0, mk(1, 2, 0, 0, 1, 0, 0));
        add(0, 0, 0, mk(1, 2, 0, 0, 1, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
        add(0, 0, 0, mk(0, 0, 1, 0, 1, 0, 0));
        add(0, 1, 2, mk(1, 2, 0, 1, 2, 0, 0));
        add(0, 0, 0, mk(1, 2, 0, 1, 2, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 1, 2, 0, 0));
        add(0, 0, 0, mk(1, 1, 0, 1, 2, 0, 0));
        add(0, 0, 0, mk(1, 1, 0, 1, 2, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 1, 2, 0, 0));
        add(0, 0, 0, mk(0, 0, 1, 1, 2, 0, 0));
        add(0, 1, 2, mk(0, 0, 1, 1, 2, 0, 0));
        add(0, 1, 1, mk(1, 2, 0, 2, 3, 0, 0));
        add(0, 1, 0, mk(1, 2, 0, 2, 3, 0, 0));
        add(0, 1, 3, mk(0, 0, 0, 2, 3, 0, 0));
        add(0, 0, 0, mk(1, 1, 0, 2, 3, 0, 0));
        add(1, 0, 0, mk(1, 1, 0, 2, 3, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 2, 3, 0, 0));
        add(0, 0, 0, mk(1, 3, 0, 2, 3, 0, 0));
        add(0, 0, 0, mk(1, 3, 0, 2, 3, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 2, 3, 0, 0));
        add(0, 0, 0, mk(0, 0, 1, 2, 3, 0, 0));
        add(0, 1, 2, mk(0, 0, 1, 2, 3, 0, 0));
        add(0, 1, 1, mk(0, 0, 1, 2, 3, 0, 0));
        add(0, 1, 3, mk(1, 2, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(1, 2, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(1, 1, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(1, 1, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(1, 3, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(1, 3, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(1, 0, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(1, 0, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(0, 0, 0, 3, 4, 0, 0));
        add(0, 0, 0, mk(0, 0, 1, 3, 4, 0, 0));
        add(0, 1, 2, mk(0, 0, 1, 3, 4, 0, 0));
        add(0, 1, 1, mk(0, 0, 1, 3, 4, 0, 0));
        add(0, 1, 3, mk(0, 0, 1, 3, 4, 0, 0));
        add(0, 1, 0, mk(0, 0, 0, 4, 4, 0, 1));
        add(0, 0, 0, mk(0, 0, 0, 4, 4, 0, 1));

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut1", obs1(), '0);
        check("reset_dut2", obs2(), '0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start     = vecs[i].start;
            btn_valid = vecs[i].bv;
            btn_color = vecs[i].bc;
            tick();
            check($sformatf("vec%0d", i), obs1(), vecs[i].exp);
        end

        // Strict miss at level 2, then restart from LOSE.
        strict = 1'b1;
        start = 1'b1; tick(); idle(3);
        press(2); idle(6);
        check("strict_at_input_l2", obs1(), mk(0, 0, 1, 1, 2, 0, 0));
        press(2); press(3);
        check("strict_lose", obs1(), mk(0, 0, 0, 1, 2, 1, 0));
        idle(1);
        check("lose_holds", obs1(), mk(0, 0, 0, 1, 2, 1, 0));
        start = 1'b1; tick();
        check("restart_from_lose", obs1(), mk(1, 2, 0, 0, 1, 0, 0));

        // Lenient miss replays level 2; no timeout when disabled.
        idle(3); press(2); idle(6);
        idle(10);
        check("no_timeout_when_0", obs1(), mk(0, 0, 1, 1, 2, 0, 0));
        strict = 1'b0;
        press(2); press(3);
        check("lenient_replay_start", obs1(), mk(1, 2, 0, 1, 2, 0, 0));
        idle(1);
        check("replay_el0", obs1(), mk(1, 2, 0, 1, 2, 0, 0));
        idle(2);
        check("replay_el1", obs1(), mk(1, 1, 0, 1, 2, 0, 0));
        idle(3);
        check("replay_input", obs1(), mk(0, 0, 1, 1, 2, 0, 0));
        press(2); press(1);
        check("replay_success", obs1(), mk(1, 2, 0, 2, 3, 0, 0));

        // Asynchronous reset mid-SHOW.
        reset = 1'b0;
        #2;
        check("async_reset_show", obs1(), '0);
        reset = 1'b1;
        idle(2);
        check("post_reset_idle", obs1(), '0);

        // Timeout instance: 8 idle cycles in INPUT is a strict miss.
        strict = 1'b1;
        start2 = 1'b1; tick();
        check("d2_show_col3", obs2(), mk(1, 3, 0, 0, 1, 0, 0));
        idle(3);
        check("d2_input", obs2(), mk(0, 0, 1, 0, 1, 0, 0));
        idle(7);
        check("d2_before_timeout", obs2(), mk(0, 0, 1, 0, 1, 0, 0));
        idle(1);
        check("d2_timeout_lose", obs2(), mk(0, 0, 0, 0, 1, 1, 0));

        // Out-of-range colour 3 misses even though the stored element is 3.
        start2 = 1'b1; tick(); idle(3);
        btn_valid2 = 1'b1; btn_color2 = 2'd3; tick();
        check("d2_invalid_color", obs2(), mk(0, 0, 0, 0, 1, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
